// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//
// Purpose:
//   Switches the instruction ROM's program counter between normal flow and the
//   single interrupt handler. The controller:
//     - latches rising edges from NUM_SRC request lines into pending bits,
//     - gates the pending bits with a mask register and a global enable,
//     - picks one source by fixed priority (bit 0 highest),
//     - pulses interrupt_jump (save PC, enter handler) and
//       interrupt_clear_status (restore saved PC) towards the ROM.
//   The ROM keeps only one saved PC, so interrupts never nest. After a return
//   there is one quiet cycle, so at least one instruction of the interrupted
//   program runs before the next interrupt is taken.
//
// Configuration macro:
//   IRQ_SYNC_EN - when defined, each request line goes through a two-flop
//                 synchronizer before edge detection (rise to pending: 3 edges).
//                 When undefined, the request lines must be synchronous to
//                 i_clk (rise to pending: 1 edge).
//
// Parameters:
//   NUM_SRC    - number of interrupt sources (1..8)
//   ID_W       - width of o_irq_id, at least ceil(log2(NUM_SRC)), minimum 1
//   MASK_RESET - reset value of the mask register (1 = source enabled)
//
// Ports:
//   i_clk                    in   system clock, rising edge
//   i_rst_n                  in   asynchronous active-low reset
//   i_irq_in[NUM_SRC]        in   raw request lines, rising-edge sensitive
//   i_global_en              in   global interrupt enable
//   i_mask_we                in   mask register write strobe
//   i_mask_wdata[NUM_SRC]    in   new mask value
//   i_pend_clr[NUM_SRC]      in   one-cycle strobe clearing selected pending bits
//   i_jump_enable            in   CPU branch to the ROM this cycle
//   i_reti                   in   decoded return-from-interrupt, one-cycle strobe
//   o_interrupt_jump         out  to ROM: save PC and jump to handler entry
//   o_interrupt_clear_status out  to ROM: restore the saved PC
//   o_irq_active             out  high while a handler is in service
//   o_irq_id[ID_W]           out  index of the source being serviced
//   o_pending[NUM_SRC]       out  latched pending bits
//   o_mask[NUM_SRC]          out  current mask register
// -----------------------------------------------------------------------------
module irq_controller #(
    parameter int                   NUM_SRC    = 4,
    parameter int                   ID_W       = 2,
    parameter logic [NUM_SRC-1:0]   MASK_RESET = '0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_SRC-1:0]  i_irq_in,
    input  logic                i_global_en,
    input  logic                i_mask_we,
    input  logic [NUM_SRC-1:0]  i_mask_wdata,
    input  logic [NUM_SRC-1:0]  i_pend_clr,
    input  logic                i_jump_enable,
    input  logic                i_reti,
    output logic                o_interrupt_jump,
    output logic                o_interrupt_clear_status,
    output logic                o_irq_active,
    output logic [ID_W-1:0]     o_irq_id,
    output logic [NUM_SRC-1:0]  o_pending,
    output logic [NUM_SRC-1:0]  o_mask
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVICE = 2'd1,
        ST_RETURN  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [NUM_SRC-1:0]     r_irq_prev;
    logic [NUM_SRC-1:0]     r_pending;
    logic [NUM_SRC-1:0]     r_mask;
    logic [ID_W-1:0]        r_irq_id;
    logic                   r_irq_active;

    logic [NUM_SRC-1:0]     w_irq_s;
    logic [NUM_SRC-1:0]     w_edge;
    logic [NUM_SRC-1:0]     w_req;
    logic [NUM_SRC-1:0]     w_accept_clr;
    logic [NUM_SRC-1:0]     w_pending_next;
    logic [ID_W-1:0]        w_win_id;
    logic                   w_any_req;
    logic                   w_accept;
    logic                   w_release;

    // -------------------------------------------------------------------------
    // Request sampling
    // -------------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0]     r_sync1;
    logic [NUM_SRC-1:0]     r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_irq_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irq_s = r_sync2;
`else
    assign w_irq_s = i_irq_in;
`endif

    // One event per rising edge; a level held high only fires once.
    assign w_edge = w_irq_s & ~r_irq_prev;

    // -------------------------------------------------------------------------
    // Request gating and fixed-priority winner (lowest index wins)
    // -------------------------------------------------------------------------
    assign w_req     = r_pending & r_mask;
    assign w_any_req = |w_req;

    // Scan from the top down so the lowest set index is the last to assign.
    always_comb begin
        w_win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_win_id = ID_W'(i);
            end
        end
    end

    // Accept only from IDLE and never in a cycle where the CPU itself drives
    // the ROM's branch input; a blocked request stays pending and retries.
    assign w_accept  = (r_state == ST_IDLE) & i_global_en & w_any_req & ~i_jump_enable;
    assign w_release = (r_state == ST_SERVICE) & i_reti;

    // -------------------------------------------------------------------------
    // Pending bit next-state: edge set beats acceptance clear beats pend_clr.
    // An edge arriving on the bit being accepted therefore re-arms it.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
            assign w_accept_clr[gi]   = w_accept & (w_win_id == ID_W'(gi));
            assign w_pending_next[gi] = w_edge[gi]       ? 1'b1 :
                                        w_accept_clr[gi] ? 1'b0 :
                                        i_pend_clr[gi]   ? 1'b0 :
                                                           r_pending[gi];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_mask     <= MASK_RESET;
        end else begin
            r_irq_prev <= w_irq_s;
            r_pending  <= w_pending_next;
            if (i_mask_we) begin
                r_mask <= i_mask_wdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Service state machine
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_irq_id     <= '0;
            r_irq_active <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_irq_id     <= w_win_id;
                        r_irq_active <= 1'b1;
                        r_state      <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (i_reti) begin
                        r_irq_active <= 1'b0;
                        r_state      <= ST_RETURN;
                    end
                end
                // One quiet cycle after the PC is restored; irq_id is kept.
                ST_RETURN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_irq_active <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    // The ROM pulses must be seen in the same cycle as the deciding inputs,
    // so they are decoded from the state rather than registered.
    assign o_interrupt_jump         = w_accept;
    assign o_interrupt_clear_status = w_release;
    assign o_irq_active             = r_irq_active;
    assign o_irq_id                 = r_irq_id;
    assign o_pending                = r_pending;
    assign o_mask                   = r_mask;

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller that sequences the instruction ROM's program counter between normal flow and the interrupt handler at the fixed handler entry.
- Latches edges from NUM_SRC sources and applies a mask and a global enable. Picks one source by fixed priority.
- Drives the ROM's interrupt_jump and interrupt_clear_status pulses.
- Tracks the in-service state so that interrupts never nest; the ROM holds only one saved PC.

Parameters:
NUM_SRC, 4, number of interrupt sources (1..8)
ID_W, 2, width of irq_id; must be at least ceil(log2(NUM_SRC)), minimum 1
MASK_RESET, {NUM_SRC{1'b0}}, reset value of the mask register (1 = source enabled)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
irq_in  in  NUM_SRC  raw interrupt request lines, rising-edge sensitive
global_en  in  1  global interrupt enable
mask_we  in  1  write strobe for the mask register
mask_wdata  in  NUM_SRC  new mask value
pend_clr  in  NUM_SRC  one-cycle strobe that clears the selected pending bits
jump_enable  in  1  CPU branch request to the ROM in this cycle; the interrupt must not collide with it
reti  in  1  decoded return-from-interrupt instruction, one-cycle strobe
interrupt_jump  out  1  to ROM: save PC and go to the handler entry
interrupt_clear_status  out  1  to ROM: restore the saved PC
irq_active  out  1  high while a handler is in service
irq_id  out  ID_W  index of the source being serviced
pending  out  NUM_SRC  latched pending bits
mask  out  NUM_SRC  current mask register

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pending=0, mask=MASK_RESET, irq_id=0, edge-history regs=0.
  - interrupt_jump=0, interrupt_clear_status=0, irq_active=0.
- Edge detect:
  - edge = irq_s & ~irq_prev, where irq_s is the sampled request.
  - pending[i] is set on the clock edge after edge[i] is seen.
  - Level-held requests produce exactly one event.
- Pending update priority per bit:
  1. set by edge (highest)
  2. clear by acceptance
  3. clear by pend_clr
- Request:
  - req = pending & mask.
  - Winner = lowest set index of req (bit 0 is the highest priority).
- State machine: IDLE, SERVICE, RETURN.
- IDLE:
  - interrupt_jump = global_en & |req & ~jump_enable. This output is combinational and valid in the same cycle.
  - When it is high, on the next edge: irq_id <= winner, pending[winner] cleared, state -> SERVICE.
  - If jump_enable=1, the interrupt is deferred, never dropped.
  - reti in IDLE is ignored; no pulse is generated.
- SERVICE:
  - irq_active=1. No new interrupt_jump, whatever pending holds.
  - On reti: interrupt_clear_status=1 (combinational, same cycle), state -> RETURN.
- RETURN:
  - Lasts one cycle with both pulses low, so at least one instruction runs before a new interrupt is taken. Then state -> IDLE.
  - irq_active=0; irq_id holds its last value.
- Mask and pending:
  - Mask write takes effect on the next edge.
  - Masked pending bits stay latched and fire once unmasked.
  - global_en=0 blocks acceptance only; pending bits still latch.
- Output guarantees:
  - interrupt_jump and interrupt_clear_status are never high in the same cycle.
  - Each is at most 1 cycle wide per event.
- Reset asserted mid-SERVICE returns to IDLE and drops all pending bits.

Optional Feature:
IRQ_SYNC_EN
- Defined:
  - Each irq_in bit passes through a 2-flop synchronizer before the edge detect. Synchronizer flops reset to 0.
  - Latency from irq_in rise to pending set is 3 clock edges.
- Undefined:
  - irq_s = irq_in. irq_in must be synchronous to clk.
  - Latency from irq_in rise to pending set is 1 edge.

Test Plan:
- Default build (IRQ_SYNC_EN undefined). mask=4'b1111, global_en=1, raise irq_in[2] at cycle 10:
  - pending[2]=1 after the cycle-10 edge; interrupt_jump=1 in cycle 11.
  - Next edge: irq_id=2, irq_active=1, pending=0.
- In SERVICE, raise irq_in[0]:
  - pending[0] sets; no interrupt_jump.
  - reti pulse -> interrupt_clear_status=1 for 1 cycle, then 1 quiet RETURN cycle.
  - Next cycle interrupt_jump=1 with irq_id becoming 0.
- irq_in[1] and irq_in[3] rise in the same cycle:
  - Source 1 is taken first; source 3 stays pending and is serviced after the reti and RETURN cycle.
- Pending source 0 while jump_enable=1 for 3 cycles:
  - interrupt_jump stays 0 for those cycles and asserts in the first cycle jump_enable=0.
- mask=0 with irq_in[0] edge:
  - pending[0]=1, no jump.
  - Write mask=4'b0001 -> interrupt_jump the cycle after the write.
  - Also: pend_clr=4'b0001 before unmask -> no jump.
- Assert rst=0 asynchronously mid-SERVICE:
  - Immediately irq_active=0, pending=0, mask=MASK_RESET, with no clock edge needed.
  - With IRQ_SYNC_EN defined: pending sets 3 edges after irq_in rises.
